// File: rtl/cci_host_mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cci_host_mem_responder
//
// Host-memory model standing in for the FIU. Read requests (c0Tx) are queued
// and answered from an internal line memory after RD_LATENCY cycles. Write
// requests (c1Tx) update the memory immediately and are acknowledged after
// WR_LATENCY cycles. Both queues drain in order, at most one response per
// cycle. A free-running 16-bit stamp records each accept, and a queue head
// leaves once its modulo-2^16 age reaches latency-1. The response register
// adds the final cycle.
//
// Optional build macro:
//   CCI_RSP_JITTER_EN - a 16-bit LFSR (seed 0xACE1) randomly stalls each queue
//                       head. Order is kept, and responses can only come later.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   rd_req_valid/addr/mdata          read request
//   rd_almfull                       read queue almost full (registered)
//   wr_req_valid/addr/data/mdata     write request
//   wr_almfull                       write queue almost full (registered)
//   rd_rsp_valid/data/mdata          read response (1-cycle pulse)
//   wr_rsp_valid/mdata               write ack (1-cycle pulse)
//   rd_outstanding, wr_outstanding   accepted but not yet answered (saturating)
//   overflow                         sticky: request seen while queue full
// -----------------------------------------------------------------------------
module cci_host_mem_responder #(
  parameter int MEM_DEPTH       = 1024,
  parameter int ADDR_W          = 42,
  parameter int DATA_W          = 512,
  parameter int MDATA_W         = 16,
  parameter int RD_LATENCY      = 8,
  parameter int WR_LATENCY      = 4,
  parameter int REQ_FIFO_DEPTH  = 64,
  parameter int ALM_FULL_MARGIN = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rd_req_valid,
  input  logic [ADDR_W-1:0]  rd_req_addr,
  input  logic [MDATA_W-1:0] rd_req_mdata,
  output logic               rd_almfull,
  input  logic               wr_req_valid,
  input  logic [ADDR_W-1:0]  wr_req_addr,
  input  logic [DATA_W-1:0]  wr_req_data,
  input  logic [MDATA_W-1:0] wr_req_mdata,
  output logic               wr_almfull,
  output logic               rd_rsp_valid,
  output logic [DATA_W-1:0]  rd_rsp_data,
  output logic [MDATA_W-1:0] rd_rsp_mdata,
  output logic               wr_rsp_valid,
  output logic [MDATA_W-1:0] wr_rsp_mdata,
  output logic [15:0]        rd_outstanding,
  output logic [15:0]        wr_outstanding,
  output logic               overflow
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(REQ_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ALM_THRESH = CNT_W'(REQ_FIFO_DEPTH - ALM_FULL_MARGIN);
  localparam logic [15:0]      RD_POP_AGE = 16'(RD_LATENCY - 1);
  localparam logic [15:0]      WR_POP_AGE = 16'(WR_LATENCY - 1);

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [MDATA_W-1:0] mdata;
    logic [15:0]        stamp;
  } rd_entry_t;

  typedef struct packed {
    logic [MDATA_W-1:0] mdata;
    logic [15:0]        stamp;
  } wr_entry_t;

  // Storage
  logic [DATA_W-1:0] mem     [MEM_DEPTH];
  rd_entry_t         rd_fifo [REQ_FIFO_DEPTH];
  wr_entry_t         wr_fifo [REQ_FIFO_DEPTH];

  // State
  logic [15:0]        stamp_q,          stamp_d;
  logic [PTR_W-1:0]   rd_wptr_q,        rd_wptr_d;
  logic [PTR_W-1:0]   rd_rptr_q,        rd_rptr_d;
  logic [CNT_W-1:0]   rd_cnt_q,         rd_cnt_d;
  logic [PTR_W-1:0]   wr_wptr_q,        wr_wptr_d;
  logic [PTR_W-1:0]   wr_rptr_q,        wr_rptr_d;
  logic [CNT_W-1:0]   wr_cnt_q,         wr_cnt_d;
  logic               rd_rsp_valid_q,   rd_rsp_valid_d;
  logic [DATA_W-1:0]  rd_rsp_data_q,    rd_rsp_data_d;
  logic [MDATA_W-1:0] rd_rsp_mdata_q,   rd_rsp_mdata_d;
  logic               wr_rsp_valid_q,   wr_rsp_valid_d;
  logic [MDATA_W-1:0] wr_rsp_mdata_q,   wr_rsp_mdata_d;
  logic               rd_almfull_q,     rd_almfull_d;
  logic               wr_almfull_q,     wr_almfull_d;
  logic [15:0]        rd_outstanding_q, rd_outstanding_d;
  logic [15:0]        wr_outstanding_q, wr_outstanding_d;
  logic               overflow_q,       overflow_d;

  // Control
  logic       rd_full, wr_full;
  logic       rd_accept, wr_accept;
  logic       rd_pop, wr_pop;
  logic       rd_stall, wr_stall;
  rd_entry_t  rd_head;
  wr_entry_t  wr_head;
  logic [15:0] rd_age, wr_age;

  // The memory aliases, so upper address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_req_addr[ADDR_W-1:IDX_W], wr_req_addr[ADDR_W-1:IDX_W]};

`ifdef CCI_RSP_JITTER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11.
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  // Stalling only the head can delay a response but never reorder or hasten it.
  assign rd_stall = (lfsr_q[1:0] == 2'b11);
  assign wr_stall = (lfsr_q[3:2] == 2'b11);
`else
  assign rd_stall = 1'b0;
  assign wr_stall = 1'b0;
`endif

  assign rd_full   = (rd_cnt_q == FIFO_FULL);
  assign wr_full   = (wr_cnt_q == FIFO_FULL);
  assign rd_accept = rd_req_valid && !rd_full;
  assign wr_accept = wr_req_valid && !wr_full;

  assign rd_head = rd_fifo[rd_rptr_q];
  assign wr_head = wr_fifo[wr_rptr_q];

  // Modulo-2^16 subtraction keeps the age correct across stamp wrap-around.
  assign rd_age = stamp_q - rd_head.stamp;
  assign wr_age = stamp_q - wr_head.stamp;

  assign rd_pop = (rd_cnt_q != '0) && (rd_age >= RD_POP_AGE) && !rd_stall;
  assign wr_pop = (wr_cnt_q != '0) && (wr_age >= WR_POP_AGE) && !wr_stall;

  function automatic logic [15:0] count_step(input logic [15:0] cur,
                                             input logic inc, input logic dec);
    logic [15:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != 16'hFFFF)      nxt = cur + 16'd1;
    else if (dec && !inc && cur != 16'h0000) nxt = cur - 16'd1;
    return nxt;
  endfunction

  function automatic logic [CNT_W-1:0] fifo_count(input logic [CNT_W-1:0] cur,
                                                  input logic push, input logic pop);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (push && !pop)      nxt = cur + CNT_W'(1);
    else if (pop && !push) nxt = cur - CNT_W'(1);
    return nxt;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    stamp_d          = stamp_q + 16'd1;

    rd_wptr_d        = rd_accept ? rd_wptr_q + PTR_W'(1) : rd_wptr_q;
    rd_rptr_d        = rd_pop    ? rd_rptr_q + PTR_W'(1) : rd_rptr_q;
    rd_cnt_d         = fifo_count(rd_cnt_q, rd_accept, rd_pop);
    wr_wptr_d        = wr_accept ? wr_wptr_q + PTR_W'(1) : wr_wptr_q;
    wr_rptr_d        = wr_pop    ? wr_rptr_q + PTR_W'(1) : wr_rptr_q;
    wr_cnt_d         = fifo_count(wr_cnt_q, wr_accept, wr_pop);

    // Memory is read in the pop cycle; a write accepted earlier has already
    // landed, so a read popped after the write sees the new line.
    rd_rsp_valid_d   = rd_pop;
    rd_rsp_data_d    = rd_rsp_data_q;
    rd_rsp_mdata_d   = rd_rsp_mdata_q;
    if (rd_pop) begin
      rd_rsp_data_d  = mem[rd_head.idx];
      rd_rsp_mdata_d = rd_head.mdata;
    end

    wr_rsp_valid_d   = wr_pop;
    wr_rsp_mdata_d   = wr_pop ? wr_head.mdata : wr_rsp_mdata_q;

    // Registered from the next count, so the flag tracks the current count.
    rd_almfull_d     = (rd_cnt_d >= ALM_THRESH);
    wr_almfull_d     = (wr_cnt_d >= ALM_THRESH);

    rd_outstanding_d = count_step(rd_outstanding_q, rd_accept, rd_pop);
    wr_outstanding_d = count_step(wr_outstanding_q, wr_accept, wr_pop);

    overflow_d       = overflow_q | (rd_req_valid && rd_full) | (wr_req_valid && wr_full);
  end

  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples the values present before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stamp_q          <= '0;
      rd_wptr_q        <= '0;
      rd_rptr_q        <= '0;
      rd_cnt_q         <= '0;
      wr_wptr_q        <= '0;
      wr_rptr_q        <= '0;
      wr_cnt_q         <= '0;
      rd_rsp_valid_q   <= 1'b0;
      rd_rsp_data_q    <= '0;
      rd_rsp_mdata_q   <= '0;
      wr_rsp_valid_q   <= 1'b0;
      wr_rsp_mdata_q   <= '0;
      rd_almfull_q     <= 1'b0;
      wr_almfull_q     <= 1'b0;
      rd_outstanding_q <= '0;
      wr_outstanding_q <= '0;
      overflow_q       <= 1'b0;
    end else begin
      stamp_q          <= stamp_d;
      rd_wptr_q        <= rd_wptr_d;
      rd_rptr_q        <= rd_rptr_d;
      rd_cnt_q         <= rd_cnt_d;
      wr_wptr_q        <= wr_wptr_d;
      wr_rptr_q        <= wr_rptr_d;
      wr_cnt_q         <= wr_cnt_d;
      rd_rsp_valid_q   <= rd_rsp_valid_d;
      rd_rsp_data_q    <= rd_rsp_data_d;
      rd_rsp_mdata_q   <= rd_rsp_mdata_d;
      wr_rsp_valid_q   <= wr_rsp_valid_d;
      wr_rsp_mdata_q   <= wr_rsp_mdata_d;
      rd_almfull_q     <= rd_almfull_d;
      wr_almfull_q     <= wr_almfull_d;
      rd_outstanding_q <= rd_outstanding_d;
      wr_outstanding_q <= wr_outstanding_d;
      overflow_q       <= overflow_d;
    end
  end

  // NOTE: line memory and queue payloads have no reset; emptying the queues
  // only needs the pointers and counts, and memory must survive reset anyway.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_req_addr[IDX_W-1:0]] <= wr_req_data;
    if (rd_accept) rd_fifo[rd_wptr_q] <= '{idx: rd_req_addr[IDX_W-1:0], mdata: rd_req_mdata, stamp: stamp_q};
    if (wr_accept) wr_fifo[wr_wptr_q] <= '{mdata: wr_req_mdata, stamp: stamp_q};
  end

  assign rd_almfull     = rd_almfull_q;
  assign wr_almfull     = wr_almfull_q;
  assign rd_rsp_valid   = rd_rsp_valid_q;
  assign rd_rsp_data    = rd_rsp_data_q;
  assign rd_rsp_mdata   = rd_rsp_mdata_q;
  assign wr_rsp_valid   = wr_rsp_valid_q;
  assign wr_rsp_mdata   = wr_rsp_mdata_q;
  assign rd_outstanding = rd_outstanding_q;
  assign wr_outstanding = wr_outstanding_q;
  assign overflow       = overflow_q;

endmodule
